angle_sector_det: RTL

ANGLE_SECTOR_DET -- requirements
Module: angle_sector_det

---
 rtl/angle_sector_det.sv | 120 ++++++++++++
 1 files changed

// File: rtl/angle_sector_det.sv
// Angle sector detector: scans the 12 sector axes (30 deg apart) and reports the
// sector whose axis gives the largest projection of X, plus that projection.
//
// state  | meaning
// IDLE   | waiting for st; latches X and clears the iteration counter on start
// SEARCH | one sector per cycle, counter 0..11, tracks best projection
// DONE   | publishes k/Mag, pulses done on the following cycle boundary
module angle_sector_det (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               st,
   input  logic signed [15:0] Xre,
   input  logic signed [15:0] Xim,
   output logic        [3:0]  k,
   output logic signed [15:0] Mag,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   state_t             state_q, state_d;
   logic        [3:0]  cnt_q;
   logic        [3:0]  best_k_q;
   logic signed [15:0] x_re_q, x_im_q;
   logic signed [34:0] best_q;
   logic signed [17:0] cos_k, sin_k;
   logic        [33:0] p_re, p_im;
   logic signed [34:0] y_re;
   logic signed [18:0] best_sh;
   logic signed [15:0] mag_sat;

   always_comb begin
      cos_k = 18'sd0;
      sin_k = 18'sd0;
      case (cnt_q)
         4'd0:  begin cos_k =  18'sd65536; sin_k =  18'sd0;     end
         4'd1:  begin cos_k =  18'sd56756; sin_k =  18'sd32768; end
         4'd2:  begin cos_k =  18'sd32768; sin_k =  18'sd56756; end
         4'd3:  begin cos_k =  18'sd0;     sin_k =  18'sd65536; end
         4'd4:  begin cos_k = -18'sd32768; sin_k =  18'sd56756; end
         4'd5:  begin cos_k = -18'sd56756; sin_k =  18'sd32768; end
         4'd6:  begin cos_k = -18'sd65536; sin_k =  18'sd0;     end
         4'd7:  begin cos_k = -18'sd56756; sin_k = -18'sd32768; end
         4'd8:  begin cos_k = -18'sd32768; sin_k = -18'sd56756; end
         4'd9:  begin cos_k =  18'sd0;     sin_k = -18'sd65536; end
         4'd10: begin cos_k =  18'sd32768; sin_k = -18'sd56756; end
         4'd11: begin cos_k =  18'sd56756; sin_k = -18'sd32768; end
         default: begin cos_k = 18'sd0; sin_k = 18'sd0; end
      endcase
   end

   // Sign-extend to 34 bits so the low 34 bits of the product are the exact signed result
   assign p_re = {{18{x_re_q[15]}}, x_re_q} * {{16{cos_k[17]}}, cos_k};
   assign p_im = {{18{x_im_q[15]}}, x_im_q} * {{16{sin_k[17]}}, sin_k};
   assign y_re = $signed({p_re[33], p_re}) + $signed({p_im[33], p_im});

   assign best_sh = best_q[34:16];

   always_comb begin
      if (best_sh > 19'sd32767)
         mag_sat = 16'sh7fff;
      else if (best_sh < -19'sd32768)
         mag_sat = 16'sh8000;
      else
         mag_sat = best_sh[15:0];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (st) state_d = SEARCH;
         SEARCH:  if (cnt_q == 4'd11) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         best_k_q <= 4'd0;
         best_q   <= 35'sd0;
         x_re_q   <= 16'sd0;
         x_im_q   <= 16'sd0;
         k        <= 4'd0;
         Mag      <= 16'sd0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_q == SEARCH);
         done    <= (state_q == DONE);
         case (state_q)
            IDLE: begin
               if (st) begin
                  x_re_q <= Xre;
                  x_im_q <= Xim;
                  cnt_q  <= 4'd0;
               end
            end
            SEARCH: begin
               cnt_q <= cnt_q + 4'd1;
               // strict compare keeps the lowest k on ties
               if (cnt_q == 4'd0 || y_re > best_q) begin
                  best_q   <= y_re;
                  best_k_q <= cnt_q;
               end
            end
            DONE: begin
               k   <= best_k_q;
               Mag <= mag_sat;
            end
            default: ;
         endcase
      end
   end

endmodule
